// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto a configuration chain and releases pad isolation after a full load.
// Optional build macro: CCFF_TAIL_CHECK_EN (checks that the first CHAIN_LEN bits leaving ccff_tail are all 0).
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   word_bits_q, word_bits_d;
    logic              head_q, head_d;
    logic              clk_en_q, clk_en_d;
    logic              ready_q, ready_d;
    logic              isol_n_q, isol_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // State and registered outputs
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            head_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            ready_q     <= 1'b0;
            isol_n_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_bits_q <= word_bits_d;
            head_q      <= head_d;
            clk_en_q    <= clk_en_d;
            ready_q     <= ready_d;
            isol_n_q    <= isol_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_bits_d = word_bits_q;
        head_d      = head_q;
        clk_en_d    = 1'b0;
        isol_n_d    = isol_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

`ifdef CCFF_TAIL_CHECK_EN
        // A cleared chain must only ever emit zeros while the first load passes through
        if (clk_en_q && ccff_tail) begin
            err_d = 1'b1;
        end
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    bit_cnt_d   = '0;
                    word_bits_d = '0;
                    err_d       = 1'b0;
                    done_d      = 1'b0;
                    isol_n_d    = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            LOAD: begin
                if (word_valid && ready_q) begin
                    shreg_d     = word_data;
                    word_bits_d = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                head_d      = shreg_q[WORD_W-1];
                clk_en_d    = 1'b1;
                shreg_d     = shreg_q << 1;
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                word_bits_d = word_bits_q + WB_W'(1);
                // Chain-full wins over word-empty so a partial last word drops its low bits
                if (bit_cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    isol_n_d = 1'b1;
                end else if (word_bits_q == LAST_WBIT) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LOAD);
    end

`ifndef CCFF_TAIL_CHECK_EN
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    assign word_ready  = ready_q;
    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign IO_ISOL_N   = isol_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: one 8-bit chain instance and one 12-bit chain instance.
module tb_ccff_bitstream_loader;

    logic       prog_clk = 1'b0;
    logic       pReset   = 1'b1;

    logic       start = 1'b0, word_valid = 1'b0, ccff_tail = 1'b0;
    logic [7:0] word_data = 8'h00;
    logic       word_ready, ccff_head, ccff_clk_en, IO_ISOL_N, busy, done, err;

    logic       start_b = 1'b0, word_valid_b = 1'b0, ccff_tail_b = 1'b0;
    logic [7:0] word_data_b = 8'h00;
    logic       word_ready_b, ccff_head_b, ccff_clk_en_b, IO_ISOL_N_b, busy_b, done_b, err_b;

    int tests = 0;
    int fails = 0;

`ifdef CCFF_TAIL_CHECK_EN
    localparam logic TAIL_ERR_EXP = 1'b1;
`else
    localparam logic TAIL_ERR_EXP = 1'b0;
`endif

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
        .IO_ISOL_N(IO_ISOL_N), .busy(busy), .done(done), .err(err)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b),
        .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
        .ccff_head(ccff_head_b), .ccff_clk_en(ccff_clk_en_b), .ccff_tail(ccff_tail_b),
        .IO_ISOL_N(IO_ISOL_N_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic start_a();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_a(input logic [7:0] w);
        int n;
        n = 0;
        word_data  = w;
        word_valid = 1'b1;
        while (!word_ready && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if (word_ready !== 1'b1) begin
            fails++;
            $display("FAIL feed_ready_timeout: word_ready=%b expected 1", word_ready);
        end
        tick();
        word_valid = 1'b0;
    endtask

    // Run ncyc cycles collecting head bits on clk_en; optionally raise tail / start after a given pulse
    task automatic collect_a(input int ncyc, input int tail_at, input int start_at,
                             output logic [15:0] bits, output int pulses, output int first_idx);
        bits = '0;
        pulses = 0;
        first_idx = -1;
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            start = 1'b0;
            ccff_tail = 1'b0;
            if (ccff_clk_en === 1'b1) begin
                pulses++;
                bits = {bits[14:0], ccff_head};
                if (first_idx < 0) first_idx = i;
                if (pulses == tail_at) ccff_tail = 1'b1;
                if (pulses == start_at) start = 1'b1;
            end
        end
        start = 1'b0;
        ccff_tail = 1'b0;
    endtask

    // Two-word load on the 12-bit chain with an optional gap before the second word
    task automatic run_b(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                         output logic [15:0] bits, output int pulses, output int ready_again,
                         output int gap_bad, output int pulses_at_resume);
        int   sent;
        int   wait_cnt;
        logic acc;
        bits = '0;
        pulses = 0;
        ready_again = 0;
        gap_bad = 0;
        pulses_at_resume = -1;
        sent = 0;
        wait_cnt = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (sent == 0 && word_ready_b) begin
                word_data_b  = w0;
                word_valid_b = 1'b1;
            end
            acc = word_valid_b && word_ready_b;
            tick();
            if (acc) begin
                sent++;
                word_valid_b = 1'b0;
            end
            if (ccff_clk_en_b === 1'b1) begin
                pulses++;
                bits = {bits[14:0], ccff_head_b};
            end
            if (sent == 2 && word_ready_b) ready_again++;
            if (sent == 1 && word_ready_b && !word_valid_b) begin
                if (wait_cnt > 0 && (ccff_clk_en_b || IO_ISOL_N_b || !busy_b)) gap_bad++;
                if (wait_cnt < gap) begin
                    wait_cnt++;
                end else begin
                    word_data_b      = w1;
                    word_valid_b     = 1'b1;
                    pulses_at_resume = pulses;
                end
            end
        end
        word_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        tick();
        tick();
        tests++;
        if ({word_ready, ccff_head, ccff_clk_en, IO_ISOL_N, busy, done, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs_a: got %b expected 0000000",
                     {word_ready, ccff_head, ccff_clk_en, IO_ISOL_N, busy, done, err});
        end
        tests++;
        if ({word_ready_b, ccff_head_b, ccff_clk_en_b, IO_ISOL_N_b, busy_b, done_b, err_b} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs_b: got %b expected 0000000",
                     {word_ready_b, ccff_head_b, ccff_clk_en_b, IO_ISOL_N_b, busy_b, done_b, err_b});
        end
        pReset = 1'b0;
        tick();
    endtask

    task automatic test_idle_ignores_valid();
        word_data  = 8'hFF;
        word_valid = 1'b1;
        tick();
        tick();
        tick();
        word_valid = 1'b0;
        tests++;
        if ({word_ready, ccff_clk_en, busy} !== 3'b000) begin
            fails++;
            $display("FAIL idle_ignores_valid: ready/clk_en/busy=%b expected 000",
                     {word_ready, ccff_clk_en, busy});
        end
    endtask

    task automatic test_basic_a5();
        logic [15:0] bits;
        int pulses, first_idx;
        start_a();
        tests++;
        if ({word_ready, busy, IO_ISOL_N, done} !== 4'b1100) begin
            fails++;
            $display("FAIL basic_after_start: ready/busy/isol_n/done=%b expected 1100",
                     {word_ready, busy, IO_ISOL_N, done});
        end
        feed_a(8'hA5);
        collect_a(14, 0, 0, bits, pulses, first_idx);
        tests++;
        if (bits[7:0] !== 8'hA5) begin
            fails++;
            $display("FAIL basic_bits: got %h expected a5", bits[7:0]);
        end
        tests++;
        if (pulses !== 8) begin
            fails++;
            $display("FAIL basic_pulses: got %0d expected 8", pulses);
        end
        tests++;
        if (first_idx !== 1) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 1", first_idx);
        end
        tests++;
        if ({done, IO_ISOL_N, busy, word_ready, err} !== 5'b11000) begin
            fails++;
            $display("FAIL basic_done_state: done/isol_n/busy/ready/err=%b expected 11000",
                     {done, IO_ISOL_N, busy, word_ready, err});
        end
    endtask

    task automatic test_chain12();
        logic [15:0] bits;
        int pulses, ready_again, gap_bad, resume;
        run_b(8'hFF, 8'h3C, 0, bits, pulses, ready_again, gap_bad, resume);
        tests++;
        if (bits[11:0] !== 12'hFF3) begin
            fails++;
            $display("FAIL chain12_bits: got %h expected ff3", bits[11:0]);
        end
        tests++;
        if (pulses !== 12) begin
            fails++;
            $display("FAIL chain12_pulses: got %0d expected 12", pulses);
        end
        tests++;
        if (ready_again !== 0) begin
            fails++;
            $display("FAIL chain12_ready_again: got %0d expected 0", ready_again);
        end
        tests++;
        if ({done_b, IO_ISOL_N_b, busy_b} !== 3'b110) begin
            fails++;
            $display("FAIL chain12_done: done/isol_n/busy=%b expected 110", {done_b, IO_ISOL_N_b, busy_b});
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] bits;
        int pulses, ready_again, gap_bad, resume;
        run_b(8'hFF, 8'h3C, 5, bits, pulses, ready_again, gap_bad, resume);
        tests++;
        if (gap_bad !== 0) begin
            fails++;
            $display("FAIL bp_gap_outputs: bad cycles %0d expected 0", gap_bad);
        end
        tests++;
        if (resume !== 8) begin
            fails++;
            $display("FAIL bp_pulses_at_resume: got %0d expected 8", resume);
        end
        tests++;
        if (bits[11:0] !== 12'hFF3 || pulses !== 12) begin
            fails++;
            $display("FAIL bp_result: bits=%h pulses=%0d expected ff3 12", bits[11:0], pulses);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] bits;
        int pulses, first_idx;
        start_a();
        feed_a(8'hA5);
        collect_a(3, 0, 0, bits, pulses, first_idx);
        tests++;
        if (pulses !== 3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: pulses=%0d busy=%b expected 3 1", pulses, busy);
        end
        pReset = 1'b1;
        #1;
        tests++;
        if ({word_ready, ccff_head, ccff_clk_en, IO_ISOL_N, busy, done, err} !== 7'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got %b expected 0000000",
                     {word_ready, ccff_head, ccff_clk_en, IO_ISOL_N, busy, done, err});
        end
        tick();
        pReset = 1'b0;
        tick();
        start_a();
        feed_a(8'hA5);
        collect_a(14, 0, 0, bits, pulses, first_idx);
        tests++;
        if (bits[7:0] !== 8'hA5 || pulses !== 8 || done !== 1'b1 || IO_ISOL_N !== 1'b1) begin
            fails++;
            $display("FAIL midreset_reload: bits=%h pulses=%0d done=%b isol_n=%b expected a5 8 1 1",
                     bits[7:0], pulses, done, IO_ISOL_N);
        end
    endtask

    task automatic test_tail_check();
        logic [15:0] bits;
        int pulses, first_idx;
        start_a();
        feed_a(8'h0F);
        collect_a(14, 5, 0, bits, pulses, first_idx);
        tests++;
        if (err !== TAIL_ERR_EXP) begin
            fails++;
            $display("FAIL tail_err: got %b expected %b", err, TAIL_ERR_EXP);
        end
        tests++;
        if (done !== 1'b1 || bits[7:0] !== 8'h0F) begin
            fails++;
            $display("FAIL tail_done: done=%b bits=%h expected 1 0f", done, bits[7:0]);
        end
    endtask

    task automatic test_start_in_done();
        logic [15:0] bits;
        int pulses, first_idx;
        start_a();
        tests++;
        if ({done, IO_ISOL_N, busy, word_ready, err} !== 5'b00110) begin
            fails++;
            $display("FAIL restart_state: done/isol_n/busy/ready/err=%b expected 00110",
                     {done, IO_ISOL_N, busy, word_ready, err});
        end
        feed_a(8'h3C);
        collect_a(14, 0, 0, bits, pulses, first_idx);
        tests++;
        if (bits[7:0] !== 8'h3C || pulses !== 8) begin
            fails++;
            $display("FAIL restart_bits: bits=%h pulses=%0d expected 3c 8", bits[7:0], pulses);
        end
    endtask

    task automatic test_start_during_shift();
        logic [15:0] bits;
        int pulses, first_idx;
        start_a();
        feed_a(8'h5A);
        collect_a(14, 0, 2, bits, pulses, first_idx);
        tests++;
        if (bits[7:0] !== 8'h5A || pulses !== 8) begin
            fails++;
            $display("FAIL shift_start_bits: bits=%h pulses=%0d expected 5a 8", bits[7:0], pulses);
        end
        tests++;
        if ({done, busy, word_ready} !== 3'b100) begin
            fails++;
            $display("FAIL shift_start_state: done/busy/ready=%b expected 100", {done, busy, word_ready});
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignores_valid();
        test_basic_a5();
        test_chain12();
        test_backpressure();
        test_reset_mid_load();
        test_tail_check();
        test_start_in_done();
        test_start_during_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
